// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and dead-band FSM state encoding for the PWM modulator
package pwm_pkg;

    localparam int SAMPLE_W_DEF = 8;
    localparam int DEAD_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HI_ON = 2'd1,
        DEAD  = 2'd2,
        LO_ON = 2'd3
    } pwm_state_e;

endpackage

// File: rtl/dead_band_gen.sv
// dead_band_gen: turns the raw PWM level into complementary drives with a dead band
module dead_band_gen
    import pwm_pkg::*;
#(
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              raw,
    input  logic [DEAD_W-1:0] dead_time,
    output logic              hi,
    output logic              lo
);

    pwm_state_e        state_q, state_d, side;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              hi_q, hi_d, lo_q, lo_d;

    // follow raw; every edge parks both sides low for dead_time clocks before switching
    always_comb begin
        side    = raw ? HI_ON : LO_ON;
        state_d = state_q;
        dead_d  = dead_q;
        if (!enable) begin
            state_d = IDLE;
            dead_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = side;
        end else if (state_q == DEAD) begin
            state_d = (dead_q == DEAD_W'(1)) ? side : DEAD;
            dead_d  = dead_q - DEAD_W'(1);
        end else if (state_q != side) begin
            state_d = (dead_time == '0) ? side : DEAD;
            dead_d  = dead_time;
        end
        hi_d = (state_d == HI_ON);
        lo_d = (state_d == LO_ON);
    end

    // state, dead counter and registered drives; reset drops the drives at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dead_q  <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/pwm_modulator.sv
// pwm_modulator: period counter, one-deep sample slot and duty register feeding the dead-band driver
module pwm_modulator
    import pwm_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int DEAD_W   = DEAD_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [DEAD_W-1:0]   dead_time,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                period_start,
    output logic                underrun
);

    logic [SAMPLE_W-1:0] count_q, count_d, duty_q, duty_d, pend_q, pend_d;
    logic [DEAD_W-1:0]   dt_q, dt_d;
    logic                pend_valid_q, pend_valid_d, fresh_q, fresh_d;
    logic                wrap, accept, raw;

    assign sample_ready = !pend_valid_q;
    assign period_start = enable && !reset && (count_q == '0);
    assign underrun     = period_start && !fresh_q;
    assign raw          = count_q < duty_q;

    // fresh remembers whether the last wrap delivered a new duty; a freshly enabled period has none
    always_comb begin
        wrap         = enable && (count_q == '1);
        accept       = sample_valid && !pend_valid_q;
        count_d      = enable ? count_q + SAMPLE_W'(1) : '0;
        duty_d       = (wrap && pend_valid_q) ? pend_q : duty_q;
        pend_d       = accept ? sample : pend_q;
        pend_valid_d = accept || (pend_valid_q && !wrap);
        fresh_d      = enable && (wrap ? pend_valid_q : fresh_q);
        dt_d         = period_start ? dead_time : dt_q;
    end

    // counter, sample slot, duty and latched dead time
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            duty_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            fresh_q      <= 1'b0;
            dt_q         <= '0;
        end else begin
            count_q      <= count_d;
            duty_q       <= duty_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            fresh_q      <= fresh_d;
            dt_q         <= dt_d;
        end
    end

    dead_band_gen #(
        .DEAD_W(DEAD_W)
    ) u_dead_band (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .raw      (raw),
        .dead_time(dt_d),
        .hi       (pwm_hi),
        .lo       (pwm_lo)
    );

endmodule

// File: tb/tb_pwm_modulator.sv
// tb_pwm_modulator: directed scenarios plus random stimulus against a cycle reference model
module tb_pwm_modulator;

    logic       clock = 1'b0;
    logic       reset, enable, sample_valid;
    logic [7:0] sample;
    logic [3:0] dead_time;
    logic       sample_ready, pwm_hi, pwm_lo, period_start, underrun;

    int n_tests = 0, n_fail = 0;
    int m_cnt, m_duty, m_pend, m_out, m_gap, m_dt;
    bit m_pv, m_fresh;
    logic o_hi, o_lo, o_ps, o_ur, o_rdy;
    int p_hi, p_lo, p_gap, p_both, l_hi, l_lo, l_gap, l_both;
    int ps_seen = 0, ur_cnt = 0, both_total = 0, en_off = 0;

    always #5 clock = ~clock;

    pwm_modulator dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .dead_time   (dead_time),
        .pwm_hi      (pwm_hi),
        .pwm_lo      (pwm_lo),
        .period_start(period_start),
        .underrun    (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // m_out: 0 = both low (idle or dead gap), 1 = high side, 2 = low side
    function automatic void m_reset();
        m_cnt = 0; m_duty = 0; m_pend = 0; m_pv = 0; m_fresh = 0;
        m_out = 0; m_gap = 0; m_dt = 0;
    endfunction

    task automatic step();
        bit exp_ps, raw, acc;
        int want;
        @(negedge clock);
        {o_hi, o_lo, o_ps, o_ur, o_rdy} = {pwm_hi, pwm_lo, period_start, underrun, sample_ready};
        exp_ps = enable && !reset && m_cnt == 0;
        check("cycle", {o_hi, o_lo, o_ps, o_ur, o_rdy},
              {m_out == 1, m_out == 2, exp_ps, exp_ps && !m_fresh, !m_pv});
        if (o_ps) begin
            l_hi = p_hi; l_lo = p_lo; l_gap = p_gap; l_both = p_both;
            p_hi = 0; p_lo = 0; p_gap = 0; p_both = 0;
            ps_seen++;
        end
        p_hi += int'(o_hi);
        p_lo += int'(o_lo);
        p_gap += int'(!o_hi && !o_lo);
        p_both += int'(o_hi && o_lo);
        both_total += int'(o_hi && o_lo);
        ur_cnt += int'(o_ur);
        if (reset) m_reset();
        else begin
            raw  = m_cnt < m_duty;
            want = raw ? 1 : 2;
            if (exp_ps) m_dt = int'(dead_time);
            acc = sample_valid && !m_pv;
            if (!enable) begin
                m_out = 0; m_gap = 0;
            end else if (m_gap > 0) begin
                if (m_gap == 1) m_out = want;
                m_gap--;
            end else if (m_out == 0 || m_dt == 0) m_out = want;
            else if (m_out != want) begin
                m_out = 0; m_gap = m_dt;
            end
            if (enable && m_cnt == 255) begin
                m_fresh = m_pv;
                if (m_pv) m_duty = m_pend;
                m_pv = 0;
            end
            if (!enable) m_fresh = 0;
            if (acc) begin
                m_pend = int'(sample); m_pv = 1;
            end
            m_cnt = enable ? (m_cnt + 1) % 256 : 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic periods(input int n);
        int target, b;
        target = ps_seen + n;
        b = 0;
        while (ps_seen < target && b < 300 * n) begin
            step();
            b++;
        end
        check("period_wait", ps_seen >= target, 1);
    endtask

    task automatic offer(input logic [7:0] v);
        sample = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample = '0; sample_valid = 1'b0; dead_time = '0;
        m_reset();
        repeat (3) step();
        check("rst_out", {o_hi, o_lo, o_ps, o_ur, o_rdy}, 5'b00001);
        reset = 1'b0; enable = 1'b1;
        step();
        check("first_ps", o_ps, 1);
        check("first_ur", o_ur, 1);

        repeat (100) step();
        offer(8'h80);
        step();
        check("ready_fall", o_rdy, 0);
        periods(2);
        check("d80_hi", l_hi, 128);
        check("d80_lo", l_lo, 128);
        periods(1);
        check("d80_hi_again", l_hi, 128);
        check("d80_lo_again", l_lo, 128);

        dead_time = 4'd3;
        offer(8'h40);
        periods(2);
        check("d40_hi", l_hi, 61);
        check("d40_lo", l_lo, 189);
        check("d40_gap", l_gap, 6);
        check("d40_both", l_both, 0);

        dead_time = 4'd5;
        offer(8'h02);
        periods(2);
        check("d02_hi", l_hi, 0);
        check("d02_lo", l_lo, 251);
        check("d02_gap", l_gap, 5);

        dead_time = 4'd0;
        offer(8'hC0);
        periods(1);
        ur_cnt = 0;
        periods(2);
        check("c0_underruns", ur_cnt, 2);
        check("c0_hi_kept", l_hi, 192);
        check("c0_lo_kept", l_lo, 64);

        dead_time = 4'd8;
        periods(1);
        offer(8'h55);
        step();
        check("dead_pending", o_rdy, 0);
        check("dead_gap", {o_hi, o_lo}, 0);
        reset = 1'b1;
        m_reset();
        #1;
        check("rst_async_ready", sample_ready, 1);
        check("rst_async_out", {pwm_hi, pwm_lo, period_start, underrun}, 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rel_ps", o_ps, 1);
        check("rel_ur", o_ur, 1);

        for (int i = 0; i < 6000; i++) begin
            dead_time = 4'($urandom_range(0, 15));
            sample = 8'($urandom);
            sample_valid = ($urandom_range(0, 99) < 2);
            if (en_off > 0) begin
                enable = 1'b0;
                en_off--;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 1499) == 0) en_off = $urandom_range(1, 20);
            end
            step();
        end
        check("never_both", both_total, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
